// File: rtl/spike_packet_receiver_pkg.sv
// Shared types and defaults for the spike packet receive path.
package spike_packet_receiver_pkg;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_NUM_NEURONS = 10;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DROP_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_HOLD     = 2'd2
    } rx_state_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/spike_packet_receiver_fifo.sv
// Synchronous FIFO; pointers carry one extra MSB so full and empty are distinguishable.
module spike_packet_receiver_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [WIDTH-1:0]        i_din,
    output logic [WIDTH-1:0]        o_dout,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/spike_packet_receiver.sv
// Spike packet receiver: decodes {origin, destination}, buffers in-range packets and
// strobes each origin onto the shared source bus for the addressed local neuron.
//   state    | meaning
//   IDLE     | nothing queued at last look; pops immediately once an entry appears
//   DISPATCH | popping one entry per cycle
//   HOLD     | timestep clear asserted; no pops, input still accepted
module spike_packet_receiver
    import spike_packet_receiver_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int BASE_ADDR   = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_pkt_valid,
    input  logic [2*ADDR_W-1:0]          i_pkt_data,
    output logic                         o_pkt_ready,
    output logic [NUM_NEURONS-1:0]       o_dispatch_valid,
    output logic [ADDR_W-1:0]            o_dispatch_source,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
    output logic [DROP_W-1:0]            o_drop_count
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int ENT_W = ADDR_W + IDX_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic                   r_run;
    logic [NUM_NEURONS-1:0] r_dispatch_valid;
    logic [ADDR_W-1:0]      r_dispatch_source;
    logic [DROP_W-1:0]      r_drop_count;

    logic [ADDR_W-1:0]      w_origin;
    logic [ADDR_W-1:0]      w_dest;
    logic [ADDR_W-1:0]      w_idx;
    logic                   w_in_range;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [ENT_W-1:0]       w_fifo_din;
    logic [ENT_W-1:0]       w_fifo_dout;
    logic [CNT_W-1:0]       w_count;
    logic [CNT_W-1:0]       w_count_next;
    logic [IDX_W-1:0]       w_head_idx;
    logic [ADDR_W-1:0]      w_head_origin;

    // Destinations below BASE_ADDR wrap to large indices and fall out of range.
    assign w_origin   = i_pkt_data[2*ADDR_W-1:ADDR_W];
    assign w_dest     = i_pkt_data[ADDR_W-1:0];
    assign w_idx      = w_dest - ADDR_W'(BASE_ADDR);
    assign w_in_range = (w_idx < ADDR_W'(NUM_NEURONS));

    assign o_pkt_ready = r_run && !w_full;
    assign w_accept    = i_pkt_valid && o_pkt_ready;
    assign w_push      = w_accept && w_in_range;
    assign w_drop      = w_accept && !w_in_range;
    assign w_fifo_din  = {w_origin, w_idx[IDX_W-1:0]};

    assign w_head_origin = w_fifo_dout[ENT_W-1:IDX_W];
    assign w_head_idx    = w_fifo_dout[IDX_W-1:0];

    assign w_pop        = !i_clear && !w_empty && (r_state != ST_HOLD);
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    spike_packet_receiver_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_fifo_din),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = ST_HOLD;
        end else if (r_state == ST_HOLD) begin
            w_state_next = w_empty ? ST_IDLE : ST_DISPATCH;
        end else begin
            w_state_next = (w_count_next == '0) ? ST_IDLE : ST_DISPATCH;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run             <= 1'b0;
            r_dispatch_valid  <= '0;
            r_dispatch_source <= '0;
            r_drop_count      <= '0;
        end else begin
            r_run            <= 1'b1;
            r_dispatch_valid <= w_pop ? (NUM_NEURONS'(1) << w_head_idx) : '0;
            if (w_pop)  r_dispatch_source <= w_head_origin;
            if (w_drop) r_drop_count      <= sat_inc(r_drop_count);
        end
    end

    assign o_dispatch_valid  = r_dispatch_valid;
    assign o_dispatch_source = r_dispatch_source;
    assign o_fifo_count      = w_count;
    assign o_drop_count      = r_drop_count;

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Self-checking bench for spike_packet_receiver: vector table plus scoreboarded sequences.
`timescale 1ns/1ps
module tb_spike_packet_receiver;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        clear     = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [23:0] pkt_data  = '0;
    logic        pkt_ready;
    logic [9:0]  dv;
    logic [11:0] src;
    logic [3:0]  fcnt;
    logic [15:0] dcnt;

    spike_packet_receiver #(
        .NUM_NEURONS (10),
        .ADDR_W      (12),
        .FIFO_DEPTH  (8),
        .BASE_ADDR   (0)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_clear           (clear),
        .i_pkt_valid       (pkt_valid),
        .i_pkt_data        (pkt_data),
        .o_pkt_ready       (pkt_ready),
        .o_dispatch_valid  (dv),
        .o_dispatch_source (src),
        .o_fifo_count      (fcnt),
        .o_drop_count      (dcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [11:0] origin;
    } exp_t;

    typedef struct {
        logic [11:0] origin;
        logic [11:0] dest;
        logic [9:0]  exp_dv;
        logic        exp_drop;
    } vec_t;

    exp_t sbq[$];
    int   strobe_cycles[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   stream_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] one_hot;
        if (rst_n) begin
            if (dv != '0) begin
                strobe_cycles.push_back(cyc);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL strobe_unexpected: got dv=%b src=0x%03h expected no strobe", dv, src);
                end else begin
                    e       = sbq.pop_front();
                    one_hot = 10'd1 << e.idx;
                    chk("strobe_target", dv, one_hot);
                    chk("strobe_source", src, e.origin);
                end
            end
            if (stream_chk) chk("stream_fifo_count_le1", fcnt <= 4'd1, 1);
        end
    end

    // Offers one packet until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [11:0] origin, input logic [11:0] dest, input int budget);
        bit   acc = 1'b0;
        exp_t e;
        pkt_valid = 1'b1;
        pkt_data  = {origin, dest};
        for (int n = 0; n < budget && !acc; n++) begin
            @(negedge clk);
            acc = pkt_ready;
            @(posedge clk);
        end
        if (acc) begin
            if (dest < 12'd10) begin
                e.idx    = dest[3:0];
                e.origin = origin;
                sbq.push_back(e);
            end
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: packet 0x%06h not accepted within %0d cycles", {origin, dest}, budget);
        end
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d strobes outstanding, expected 0", name, sbq.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int   tbl_drops;
        int   n_hi;
        int   first_acc;
        int   n;

        vt[0] = '{12'hABC, 12'h000, 10'b0000000001, 1'b0};
        vt[1] = '{12'h000, 12'h003, 10'b0000001000, 1'b0};
        vt[2] = '{12'h123, 12'h009, 10'b1000000000, 1'b0};
        vt[3] = '{12'hFFF, 12'h005, 10'b0000100000, 1'b0};
        vt[4] = '{12'h001, 12'h00A, 10'b0000000000, 1'b1};
        vt[5] = '{12'h777, 12'hFFB, 10'b0000000000, 1'b1};
        vt[6] = '{12'h555, 12'hFFF, 10'b0000000000, 1'b1};
        vt[7] = '{12'h3C3, 12'h009, 10'b1000000000, 1'b0};

        // Reset values, before and across edges while held.
        #2;
        chk("rst_ready", pkt_ready, 0);
        chk("rst_dv", dv, 0);
        chk("rst_src", src, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_dcnt", dcnt, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_held", pkt_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", pkt_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_first_edge", pkt_ready, 1);

        // Reset mid-burst.
        send(12'h5A5, 12'd2, 5);
        send(12'h001, 12'd10, 5);
        pkt_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_src", src, 12'h5A5);
        chk("pre_reset_dcnt", dcnt, 1);
        clear = 1'b1;
        for (int i = 0; i < 4; i++) send(12'h401 + 12'(i), 12'd6 + 12'(i), 5);
        pkt_valid = 1'b0;
        chk("pre_reset_fcnt", fcnt, 4);
        rst_n = 1'b0;
        clear = 1'b0;
        #1;
        chk("midrst_dv", dv, 0);
        chk("midrst_src", src, 0);
        chk("midrst_fcnt", fcnt, 0);
        chk("midrst_dcnt", dcnt, 0);
        chk("midrst_ready", pkt_ready, 0);
        sbq.delete();
        strobe_cycles.delete();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready_low", pkt_ready, 0);
        @(posedge clk);
        #1;
        chk("post_rst_ready_high", pkt_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_fcnt", fcnt, 0);
        chk("post_rst_no_strobes", strobe_cycles.size(), 0);

        // Single-packet vectors.
        tbl_drops = 0;
        for (int i = 0; i < 8; i++) begin
            send(vt[i].origin, vt[i].dest, 5);
            pkt_valid = 1'b0;
            tbl_drops += int'(vt[i].exp_drop);
            chk($sformatf("vec%0d_dv_at_accept", i), dv, 0);
            chk($sformatf("vec%0d_drop_count", i), dcnt, tbl_drops);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_dv", i), dv, vt[i].exp_dv);
            if (vt[i].exp_dv != '0) chk($sformatf("vec%0d_src", i), src, vt[i].origin);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_dv_cleared", i), dv, 0);
        end

        // Drop counter saturation.
        pkt_data  = {12'h0F0, 12'd10};
        pkt_valid = 1'b1;
        chk("sat_ready", pkt_ready, 1);
        repeat (100) @(posedge clk);
        #1;
        chk("drop_after_100", dcnt, tbl_drops + 100);
        repeat (65440) @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        chk("drop_saturated", dcnt, 16'hFFFF);
        chk("sat_fifo_empty", fcnt, 0);

        // Full FIFO under clear.
        clear = 1'b1;
        strobe_cycles.delete();
        for (int i = 0; i < 8; i++) send(12'h100 + 12'(i), 12'(i), 5);
        chk("full_ready_low", pkt_ready, 0);
        chk("full_fcnt", fcnt, 8);
        pkt_valid = 1'b1;
        pkt_data  = {12'h108, 12'd8};
        repeat (3) begin
            @(negedge clk);
            chk("full_ready_stays_low", pkt_ready, 0);
        end
        @(posedge clk);
        #1;
        chk("full_fcnt_held", fcnt, 8);
        chk("full_no_strobe_in_clear", strobe_cycles.size(), 0);
        clear = 1'b0;
        send(12'h108, 12'd8, 20);
        pkt_valid = 1'b0;
        wait_drain("full_drain", 30);
        chk("full_strobe_count", strobe_cycles.size(), 9);
        chk("full_one_per_cycle", strobe_cycles[strobe_cycles.size()-1] - strobe_cycles[0], 8);

        // clear during DISPATCH.
        clear = 1'b1;
        for (int i = 0; i < 5; i++) send(12'h301 + 12'(i), 12'd1 + 12'(i), 5);
        pkt_valid = 1'b0;
        strobe_cycles.delete();
        clear = 1'b0;
        n = 0;
        while (strobe_cycles.size() < 2 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        clear = 1'b1;
        n_hi  = cyc;
        chk("mid_clear_two_strobes", strobe_cycles.size(), 2);
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b0;
        chk("mid_clear_none_while_high", strobe_cycles.size(), 2);
        wait_drain("mid_clear_drain", 20);
        chk("mid_clear_strobe_count", strobe_cycles.size(), 5);
        chk("mid_clear_first_pair", strobe_cycles[1] - strobe_cycles[0], 1);
        chk("mid_clear_resume_cycle", strobe_cycles[2] - n_hi, 6);
        chk("mid_clear_last_cycle", strobe_cycles[4] - n_hi, 8);

        // Streaming, one packet per cycle.
        strobe_cycles.delete();
        stream_chk = 1'b1;
        first_acc  = 0;
        for (int i = 0; i < 20; i++) begin
            send(12'h200 + 12'(i), 12'(i % 10), 3);
            if (i == 0) first_acc = cyc;
        end
        pkt_valid = 1'b0;
        wait_drain("stream_drain", 10);
        stream_chk = 1'b0;
        chk("stream_strobe_count", strobe_cycles.size(), 20);
        chk("stream_first_latency", strobe_cycles[0] - first_acc, 1);
        chk("stream_last_cycle", strobe_cycles[19] - first_acc, 20);

        // Identical back-to-back packets give separate strobes.
        strobe_cycles.delete();
        send(12'h0AA, 12'd4, 3);
        send(12'h0AA, 12'd4, 3);
        pkt_valid = 1'b0;
        wait_drain("dup_drain", 10);
        chk("dup_strobe_count", strobe_cycles.size(), 2);
        chk("dup_consecutive", strobe_cycles[1] - strobe_cycles[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
